// File: rtl/serial_subtractor_pkg.sv
// Shared types and a reference helper
// for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // {bout, d} packed with bout at bit w; w is at most 32.
  function automatic logic [32:0] sub_ref(
    input int unsigned w,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        bin
  );
    logic [32:0] full;
    logic [32:0] mask;
    logic        bo;
    full = {1'b0, a} - {1'b0, b} - 33'(bin);
    bo   = ({1'b0, a} < ({1'b0, b} + 33'(bin)));
    mask = (33'(1) << w) - 33'(1);
    return (full & mask) | (33'(bo) << w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell:
// diff = x - y - bi, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, one bit
// per clock through one subtractor cell.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_q;
  logic             brw_q;
  logic             fs_diff;
  logic             fs_bo;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bi   (brw_q),
    .diff (fs_diff),
    .bo   (fs_bo)
  );

  assign last    = (cnt_q == LAST);
  assign accept  = (state_q == IDLE) && start;
  // diff enters at the MSB so the word ends LSB-aligned
  assign res_nxt = {fs_diff, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      res_q <= '0;
      brw_q <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      a_sr  <= a;
      b_sr  <= b;
      res_q <= '0;
      brw_q <= bin;
    end else if (state_q == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res_q <= res_nxt;
      brw_q <= fs_bo;
      if (last) begin
        d    <= res_nxt;
        bout <= fs_bo;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
